// File: rtl/gcd_job_sequencer.sv
// Queues operand pairs in a 4-deep FIFO and runs them one at a time through an external GCD engine.
// Macro GCD_SEQ_CEN_DIV_EN: CEN becomes a one-cycle pulse every CEN_DIV cycles instead of constant 1.
module gcd_job_sequencer #(
  parameter int CEN_DIV = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       In_valid,
  output logic       In_ready,
  input  logic [7:0] In_A,
  input  logic [7:0] In_B,
  output logic       Start,
  output logic       Ack,
  output logic [7:0] Ain,
  output logic [7:0] Bin,
  output logic       CEN,
  input  logic       q_Done,
  input  logic [7:0] AB_GCD,
  output logic       Out_valid,
  input  logic       Out_ready,
  output logic [7:0] Out_A,
  output logic [7:0] Out_B,
  output logic [7:0] Out_GCD,
  output logic [7:0] Job_count
);

  if (CEN_DIV < 2 || CEN_DIV > 255) begin : g_bad_cen_div
    $error("CEN_DIV must be in 2..255");
  end

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    LOAD  = 6'b000010,
    START = 6'b000100,
    WAIT  = 6'b001000,
    ACK   = 6'b010000,
    EMIT  = 6'b100000
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] fifo_a [4];
  logic [7:0] fifo_b [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       ready_en, push, pop;
  logic [7:0] head_a, head_b, result;

  // ready_en keeps In_ready low until the first edge after reset release
  assign In_ready = ready_en && (count != 3'd4);
  assign push     = In_valid && In_ready;
  assign pop      = (state == LOAD);
  assign head_a   = fifo_a[rd_ptr];
  assign head_b   = fifo_b[rd_ptr];

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= In_A;
      fifo_b[wr_ptr] <= In_B;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ready_en <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Start     = 1'b0;
    Ack       = 1'b0;
    Out_valid = 1'b0;
    unique case (state)
      IDLE:  if (count != 3'd0) state_nxt = LOAD;
      LOAD:  state_nxt = (head_a == 8'd0 || head_b == 8'd0) ? EMIT : START;
      START: begin
        Start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (q_Done) state_nxt = ACK;
      ACK: begin
        Ack       = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        Out_valid = 1'b1;
        if (Out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A|B is already the answer when an operand is zero; engine jobs overwrite it in WAIT
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Ain       <= 8'd0;
      Bin       <= 8'd0;
      result    <= 8'd0;
      Job_count <= 8'd0;
    end else begin
      if (state == LOAD) begin
        Ain    <= head_a;
        Bin    <= head_b;
        result <= head_a | head_b;
      end
      if (state == WAIT && q_Done) result <= AB_GCD;
      if (state == EMIT && Out_ready) Job_count <= Job_count + 8'd1;
    end
  end

  assign Out_A   = Ain;
  assign Out_B   = Bin;
  assign Out_GCD = result;

`ifdef GCD_SEQ_CEN_DIV_EN
  logic [7:0] cen_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                          cen_cnt <= 8'd0;
    else if (cen_cnt == 8'(CEN_DIV - 1)) cen_cnt <= 8'd0;
    else                                 cen_cnt <= cen_cnt + 8'd1;
  end

  assign CEN = (cen_cnt == 8'(CEN_DIV - 1));
`else
  assign CEN = 1'b1;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer: behavioural GCD engine stub, queue scoreboard, vector table and corner sequences.
module tb_gcd_job_sequencer;
  localparam int NRAND = 270;

  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [7:0] g; } res_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] g; int starts; } vec_t;

  logic       Clk = 1'b0;
  logic       Reset, In_valid, In_ready, Start, Ack, CEN, q_Done, Out_valid, Out_ready;
  logic [7:0] In_A, In_B, Ain, Bin, AB_GCD, Out_A, Out_B, Out_GCD, Job_count;

  int         n_checks = 0;
  int         n_pass = 0;
  int         start_pulses = 0;
  int         ack_pulses = 0;
  int         overlap = 0;
  logic       eng_hold = 1'b0;
  logic       eng_rand = 1'b0;
  logic       sink_level = 1'b1;
  logic       rand_sink = 1'b0;
  logic [7:0] last_g = 8'd0;
  res_t       exp_q[$];
  res_t       mon_e;
  vec_t       vecs[9];

  gcd_job_sequencer #(.CEN_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .In_ready(In_ready),
    .In_A(In_A), .In_B(In_B), .Start(Start), .Ack(Ack), .Ain(Ain), .Bin(Bin),
    .CEN(CEN), .q_Done(q_Done), .AB_GCD(AB_GCD), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Out_A(Out_A), .Out_B(Out_B), .Out_GCD(Out_GCD),
    .Job_count(Job_count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
    int x = int'(a);
    int y = int'(b);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Engine stub: latches operands on Start, raises q_Done after a delay, drops it on Ack.
  initial begin
    logic eng_busy;
    int   eng_cnt;
    logic [7:0] eng_res;
    eng_busy = 1'b0;
    eng_cnt  = 0;
    eng_res  = 8'd0;
    q_Done   = 1'b0;
    AB_GCD   = 8'd0;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset) begin
        eng_busy = 1'b0;
        q_Done   = 1'b0;
      end else begin
        if (Start) begin
          start_pulses++;
          eng_busy = 1'b1;
          eng_res  = gcd8(Ain, Bin);
          eng_cnt  = eng_rand ? int'($urandom_range(0, 6)) : 3;
        end else if (eng_busy && !q_Done && !eng_hold) begin
          if (eng_cnt == 0) begin
            q_Done = 1'b1;
            AB_GCD = eng_res;
          end else begin
            eng_cnt--;
          end
        end
        if (Ack) begin
          ack_pulses++;
          q_Done   = 1'b0;
          eng_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    Out_ready = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      Out_ready = rand_sink ? 1'($urandom_range(0, 1)) : sink_level;
    end
  end

  always @(negedge Clk) begin
    if (Start && Ack) overlap++;
    if (Reset && Out_valid && Out_ready) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 32'(Out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_a", 32'(Out_A), 32'(mon_e.a));
        chk("out_b", 32'(Out_B), 32'(mon_e.b));
        chk("out_gcd", 32'(Out_GCD), 32'(mon_e.g));
        last_g = Out_GCD;
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    In_valid = 1'b1;
    In_A     = a;
    In_B     = b;
    @(negedge Clk);
    while (!In_ready && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (!In_ready) chk("push_timeout", 32'(In_ready), 32'd1);
    else exp_q.push_back('{a: a, b: b, g: gcd8(a, b)});
    @(posedge Clk);
    #1;
    In_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic wait_start(input int s0);
    int n = 0;
    while (start_pulses == s0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("start_seen", 32'(start_pulses - s0), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge Clk);
    while (!Out_valid && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("out_valid_seen", 32'(Out_valid), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(In_ready), 32'd0);
    chk({tag, "_start"}, 32'(Start), 32'd0);
    chk({tag, "_ack"}, 32'(Ack), 32'd0);
    chk({tag, "_out_valid"}, 32'(Out_valid), 32'd0);
    chk({tag, "_ain"}, 32'(Ain), 32'd0);
    chk({tag, "_bin"}, 32'(Bin), 32'd0);
    chk({tag, "_out_a"}, 32'(Out_A), 32'd0);
    chk({tag, "_out_b"}, 32'(Out_B), 32'd0);
    chk({tag, "_out_gcd"}, 32'(Out_GCD), 32'd0);
    chk({tag, "_job_count"}, 32'(Job_count), 32'd0);
  endtask

  task automatic check_cen();
    int highs = 0;
    int last = -1;
    int gap_err = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      if (CEN) begin
        if (last >= 0 && c - last != 4) gap_err++;
        highs++;
        last = c;
      end
    end
`ifdef GCD_SEQ_CEN_DIV_EN
    chk("cen_pulse_count", 32'(highs), 32'd4);
    chk("cen_pulse_gap", 32'(gap_err), 32'd0);
`else
    chk("cen_always_high", 32'(highs), 32'd16);
`endif
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int s0, a0, stable_err;
    logic [7:0] ra, rb;

    vecs[0] = '{8'd12,  8'd18,  8'd6,   1};
    vecs[1] = '{8'd0,   8'd35,  8'd35,  0};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   0};
    vecs[3] = '{8'd35,  8'd0,   8'd35,  0};
    vecs[4] = '{8'd9,   8'd6,   8'd3,   1};
    vecs[5] = '{8'd255, 8'd255, 8'd255, 1};
    vecs[6] = '{8'd1,   8'd255, 8'd1,   1};
    vecs[7] = '{8'd128, 8'd96,  8'd32,  1};
    vecs[8] = '{8'd17,  8'd13,  8'd1,   1};

    Reset = 1'b0;
    In_valid = 1'b0;
    In_A = 8'd0;
    In_B = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("in_ready_after_reset", 32'(In_ready), 32'd1);

    check_cen();

    for (int i = 0; i < 9; i++) begin
      s0 = start_pulses;
      a0 = ack_pulses;
      push(vecs[i].a, vecs[i].b);
      wait_drain();
      chk("vec_gcd", 32'(last_g), 32'(vecs[i].g));
      chk("vec_start_pulses", 32'(start_pulses - s0), 32'(vecs[i].starts));
      chk("vec_ack_pulses", 32'(ack_pulses - a0), 32'(vecs[i].starts));
      chk("vec_job_count", 32'(Job_count), 32'(i + 1));
    end

    // Burst of six behind a job parked in WAIT
    s0 = start_pulses;
    eng_hold = 1'b1;
    push(8'd100, 8'd75);
    wait_start(s0);
    for (int i = 0; i < 4; i++) begin
      push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
      if (i == 2) chk("in_ready_three_queued", 32'(In_ready), 32'd1);
    end
    @(negedge Clk);
    chk("in_ready_full", 32'(In_ready), 32'd0);
    @(posedge Clk);
    #1;
    eng_hold = 1'b0;
    for (int i = 0; i < 2; i++) push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    wait_drain();
    chk("burst_start_pulses", 32'(start_pulses - s0), 32'd7);

    // Downstream stall in EMIT with a full FIFO behind it
    sink_level = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    push(8'd12, 8'd18);
    wait_out_valid();
    for (int i = 0; i < 4; i++) push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    s0 = start_pulses;
    stable_err = 0;
    repeat (20) begin
      @(negedge Clk);
      if (!Out_valid || Out_A != 8'd12 || Out_B != 8'd18 || Out_GCD != 8'd6 || In_ready) stable_err++;
    end
    chk("emit_stall_stable", 32'(stable_err), 32'd0);
    chk("emit_stall_no_start", 32'(start_pulses - s0), 32'd0);
    @(posedge Clk);
    #1;
    sink_level = 1'b1;
    wait_drain();

    // Reset asserted while a job waits on the engine
    s0 = start_pulses;
    eng_hold = 1'b1;
    push(8'd20, 8'd30);
    wait_start(s0);
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    exp_q.delete();
    eng_hold = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("in_ready_after_rerelease", 32'(In_ready), 32'd1);
    push(8'd9, 8'd6);
    wait_drain();
    chk("post_reset_gcd", 32'(last_g), 32'd3);
    chk("post_reset_job_count", 32'(Job_count), 32'd1);

    // Randomized traffic; enough jobs to wrap Job_count
    rand_sink = 1'b1;
    eng_rand  = 1'b1;
    for (int i = 0; i < NRAND; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)) & ((i % 3 == 0) ? 8'hF0 : 8'hFF);
      push(ra, rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clk);
        #1;
      end
    end
    wait_drain();
    chk("rand_job_count_wrap", 32'(Job_count), 32'((1 + NRAND) % 256));
    chk("start_ack_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/gcd_job_sequencer.md
GCD_JOB_SEQUENCER -- requirements
Module: gcd_job_sequencer

Interface
REQ-001 Parameter: CEN_DIV, 4, CEN period in Clk cycles when the divider is compiled in; legal range 2..255.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 In_valid  in  1  operand pair offered by upstream.
REQ-005 In_ready  out  1  sequencer can accept a pair.
REQ-006 In_A, In_B  in  8 each  operand pair.
REQ-007 Start  out  1  job start to GCD engine.
REQ-008 Ack  out  1  result acknowledge to GCD engine.
REQ-009 Ain, Bin  out  8 each  operands to GCD engine.
REQ-010 CEN  out  1  step enable to GCD engine.
REQ-011 q_Done  in  1  engine DONE state flag.
REQ-012 AB_GCD  in  8  engine result.
REQ-013 Out_valid  out  1  result available downstream.
REQ-014 Out_ready  in  1  downstream accepts result.
REQ-015 Out_A, Out_B, Out_GCD  out  8 each  original operands and their GCD.
REQ-016 Job_count  out  8  completed jobs, modulo 256.

Function
REQ-017 Input queue SHALL be a 4-entry FIFO; push when In_valid & In_ready; In_ready = not full; no push when full, even if a pop occurs in the same cycle.
REQ-018 Controller SHALL be a one-hot FSM with states IDLE, LOAD, START, WAIT, ACK, EMIT.
REQ-019 IDLE: FIFO non-empty -> LOAD; else stay.
REQ-020 LOAD: capture FIFO head into operand registers and pop; either operand 0 -> EMIT, else -> START.
REQ-021 Zero-operand bypass: Out_GCD = A | B (gcd(a,0)=a, gcd(0,0)=0); engine never started.
REQ-022 Ain/Bin SHALL be registered, loaded in LOAD, and held stable until the next LOAD.
REQ-023 START: Start = 1 for exactly one cycle -> WAIT.
REQ-024 WAIT: q_Done = 1 -> capture AB_GCD into result register -> ACK; no timeout.
REQ-025 ACK: Ack = 1 for exactly one cycle -> EMIT.
REQ-026 EMIT: Out_valid = 1; Out_A/Out_B/Out_GCD held stable; Out_valid & Out_ready -> Job_count +1 (255 wraps to 0) -> IDLE.
REQ-027 Start and Ack SHALL never be high in the same cycle; both 0 outside START/ACK.
REQ-028 Results SHALL leave in push order; at most one job in flight.
REQ-029 FIFO push during LOAD pop SHALL be accepted when not full; count stays consistent.

Reset
REQ-030 Reset = 0 SHALL immediately force IDLE, empty FIFO, In_ready=0 while asserted, and Start, Ack, Out_valid, Ain, Bin, Out_A, Out_B, Out_GCD, Job_count to 0.
REQ-031 Reset mid-job SHALL discard the job; the top level drives the engine's reset from the same source, inverted.
REQ-032 In_ready = 1 from the first edge after Reset deasserts.

Configuration
REQ-033 Macro GCD_SEQ_CEN_DIV_EN defined: CEN SHALL be a one-cycle pulse every CEN_DIV cycles from a free-running counter cleared by Reset.
REQ-034 Macro undefined: CEN SHALL be constant 1 after reset; CEN_DIV unused.

Verification
REQ-035 Push (12,18) -> one Start pulse; engine result 6 gives one Ack pulse, then Out_valid with (12,18,6); Job_count = 1.
REQ-036 Push (0,35), then (0,0) -> no Start pulse; outputs (0,35,35), then (0,0,0).
REQ-037 Push 6 pairs back-to-back while a job is in WAIT -> In_ready drops after the 4th queued pair; all 6 results appear in order.
REQ-038 Out_ready = 0 for 20 cycles in EMIT -> Out_valid and data stable; no Start pulse; no pop.
REQ-039 Reset = 0 during WAIT -> outputs 0 asynchronously; after release, fresh push (9,6) yields 3.
REQ-040 GCD_SEQ_CEN_DIV_EN defined, CEN_DIV=4 -> CEN high 1 cycle in 4; undefined -> CEN constantly 1.
